// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory address/data, redirect request and the
// valid/ready stream of {pc, instr} pairs toward decode.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, tracks one in-flight memory read and
// buffers up to two fetched {pc, instr} pairs for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  logic [31:0] pc_reg, pc_next;
  logic        inflight_reg, inflight_next;
  logic [31:0] inflight_pc_reg, inflight_pc_next;
  logic [1:0]  count_reg, count_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic [31:0] fifo_pc_reg    [2];
  logic [31:0] fifo_instr_reg [2];

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ_after_pop;
  logic [1:0]  unused_rpc_bits;

  assign unused_rpc_bits = bus.redirect_pc[1:0];

  always_comb begin
    pop              = (count_reg != 2'd0) && bus.out_ready;
    push             = inflight_reg && !bus.redirect_valid;
    // Slots already claimed once this cycle's pop leaves; never exceeds 2.
    occ_after_pop    = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue            = !bus.redirect_valid && (occ_after_pop < 3'd2);

    pc_next          = pc_reg;
    inflight_next    = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    if (bus.redirect_valid) begin
      // Buffered entries, the in-flight word and any same-cycle pop are dropped.
      pc_next     = {bus.redirect_pc[31:2], 2'b00};
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      count_next  = count_reg + {1'b0, push} - {1'b0, pop};
      wr_ptr_next = wr_ptr_reg ^ push;
      rd_ptr_next = rd_ptr_reg ^ pop;
      if (issue) begin
        pc_next          = pc_reg + 32'd4;
        inflight_next    = 1'b1;
        inflight_pc_next = pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      count_reg       <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_pc_reg[gi]    <= 32'h0;
          fifo_instr_reg[gi] <= 32'h0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_pc_reg[gi]    <= inflight_pc_reg;
          fifo_instr_reg[gi] <= bus.imem_data;
        end
      end
    end
  endgenerate

  // Outputs come only from registers, so imem_data never reaches out_* combinationally.
  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_pc    = fifo_pc_reg[rd_ptr_reg];
  assign bus.out_instr = fifo_instr_reg[rd_ptr_reg];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/wrap/async-reset tasks
// plus a randomized run scored against a per-segment PC stream model.
module tb_fetch_unit;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with one-cycle read latency.
  always @(posedge clk) bus.imem_data <= bus.imem_addr ^ MEM_XOR;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (2) step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", bus.out_instr); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp 0", bus.imem_addr); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_issue_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL first_issue_addr got %h exp 4", bus.imem_addr); end
    for (int k = 0; k <= 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc k=%0d got %h exp %h", k, bus.out_pc, exp_pc); end
      checks++; if (bus.out_instr !== (exp_pc ^ MEM_XOR)) begin errors++; $display("FAIL stream_instr k=%0d got %h exp %h", k, bus.out_instr, exp_pc ^ MEM_XOR); end
      $display("reset stream: pc=%h instr=%h", bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid i=%0d got %b exp 1", i, bus.out_valid); end
      checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL stall_pc i=%0d got %h exp 0", i, bus.out_pc); end
      checks++; if (bus.out_instr !== MEM_XOR) begin errors++; $display("FAIL stall_instr i=%0d got %h exp %h", i, bus.out_instr, MEM_XOR); end
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr i=%0d got %h exp 8", i, bus.imem_addr); end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid k=%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL drain_pc k=%0d got %h exp %h", k, bus.out_pc, exp_pc); end
      $display("drain: pc=%h instr=%h", bus.out_pc, bus.out_instr);
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    step();
    bus.out_ready = 1'b0;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    bus.out_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 100", bus.imem_addr); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_gap_valid got %b exp 0", bus.out_valid); end
    for (int k = 0; k < 2; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h100 + 32'(4 * k);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL redir_valid k=%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL redir_pc k=%0d got %h exp %h", k, bus.out_pc, exp_pc); end
      checks++; if (bus.out_instr !== (exp_pc ^ MEM_XOR)) begin errors++; $display("FAIL redir_instr k=%0d got %h exp %h", k, bus.out_instr, exp_pc ^ MEM_XOR); end
      $display("redirect: pc=%h instr=%h", bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    step();
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid k=%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc k=%0d got %h exp %h", k, bus.out_pc, exp_pc); end
      checks++; if (bus.out_instr !== (exp_pc ^ MEM_XOR)) begin errors++; $display("FAIL wrap_instr k=%0d got %h exp %h", k, bus.out_instr, exp_pc ^ MEM_XOR); end
      $display("wrap: pc=%h instr=%h", bus.out_pc, bus.out_instr);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Per segment (since reset or redirect): fetch runs two words ahead of
  // delivery, so the stream appears two edges in and then never runs dry.
  task automatic test_random();
    logic [31:0] seg_start;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        stall_prev;
    logic        exp_valid;
    logic        redir;
    int          age;
    int          delivered;
    do_reset();
    seg_start  = 32'h0;
    age        = 0;
    delivered  = 0;
    stall_prev = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      exp_valid = (age >= 2);
      exp_pc    = seg_start + 32'(4 * delivered);
      exp_addr  = (age >= 2) ? seg_start + 32'(4 * (delivered + 2)) : seg_start + 32'(4 * age);
      checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, exp_valid); end
      checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, bus.imem_addr, exp_addr); end
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got %h exp %h", cyc, bus.out_pc, exp_pc); end
        checks++; if (bus.out_instr !== (bus.out_pc ^ MEM_XOR)) begin errors++; $display("FAIL rnd_instr cyc=%0d got %h exp %h", cyc, bus.out_instr, bus.out_pc ^ MEM_XOR); end
      end
      if (stall_prev) begin
        checks++; if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, prev_pc, prev_instr}) begin
          errors++; $display("FAIL rnd_stable cyc=%0d got %b/%h/%h exp 1/%h/%h", cyc, bus.out_valid, bus.out_pc, bus.out_instr, prev_pc, prev_instr);
        end
      end
      redir         = ($urandom_range(31, 0) == 0);
      bus.out_ready = 1'($urandom_range(1, 0));
      bus.redirect_valid = redir;
      bus.redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (redir) begin
        seg_start  = {bus.redirect_pc[31:2], 2'b00};
        age        = 0;
        delivered  = 0;
        stall_prev = 1'b0;
        $display("random: redirect to %h", seg_start);
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          delivered++;
          $display("random: accept pc=%h instr=%h", bus.out_pc, bus.out_instr);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_pc    = bus.out_pc;
        prev_instr = bus.out_instr;
        if (age < 2) age++;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr got %h exp 0", bus.imem_addr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL async_pc got %h exp 0", bus.out_pc); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_issue_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL async_issue_addr got %h exp 4", bus.imem_addr); end
    for (int k = 0; k <= 4; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL async_stream_valid k=%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL async_stream_pc k=%0d got %h exp %h", k, bus.out_pc, exp_pc); end
      checks++; if (bus.out_instr !== (exp_pc ^ MEM_XOR)) begin errors++; $display("FAIL async_stream_instr k=%0d got %h exp %h", k, bus.out_instr, exp_pc ^ MEM_XOR); end
      $display("restart: pc=%h instr=%h", bus.out_pc, bus.out_instr);
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_data      = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
